// File: rtl/sopc_cpu_oci_pkg.sv
// sopc_cpu_oci_pkg: trace-capture state encoding and overflow counter helpers
package sopc_cpu_oci_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

    localparam int OVF_W = 16;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sopc_cpu_oci_trace_fifo.sv
// sopc_cpu_oci_trace_fifo: circular trace buffer with stop-when-full or overwrite-oldest policy
module sopc_cpu_oci_trace_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 16,
    parameter int WRAP  = 0,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [AW:0]  level,
    output logic         ovf
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full, pop, do_wr, adv_r;

    assign full    = level == (AW+1)'(DEPTH);
    assign pop     = rd_en && level != '0;
    assign do_wr   = wr_en && (!full || pop || WRAP != 0);
    assign adv_r   = pop || (wr_en && full && WRAP != 0);
    assign ovf     = wr_en && full && !pop;
    assign rd_data = (level != '0) ? mem[rptr] : '0;

    // Storage holds no reset; only slots below level are ever observed
    always_ff @(posedge clk)
        if (do_wr) mem[wptr] <= wr_data;

    // Pointers and occupancy; a full overwrite advances both pointers together
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (adv_r) rptr <= rptr + 1'b1;
            level <= level + (AW+1)'(do_wr) - (AW+1)'(adv_r);
        end

endmodule

// File: rtl/sopc_cpu_oci_trace_capture.sv
// sopc_cpu_oci_trace_capture: armed trace capture into a buffer with drain and done sequencing
module sopc_cpu_oci_trace_capture
    import sopc_cpu_oci_pkg::*;
#(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int WRAP   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      arm,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    output logic [DATA_W+CNT_W-1:0]   rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic [OVF_W-1:0]          overflow_cnt,
    output logic [1:0]                state_o,
    output logic                      done
);

    trace_state_e state, state_nxt;
    logic         wr_en, pop, clr, ovf;

    assign rd_valid = level != '0 && (state == ST_CAPTURE || state == ST_DRAIN);
    assign wr_en    = state == ST_CAPTURE && dct_count != '0;
    assign pop      = rd_valid && rd_ready;
    assign state_o  = state;
    assign done     = state == ST_DONE;

    // State register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;

    // Next state; test_has_ended overrides everything outside IDLE, re-arm from DONE clears the buffer
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        case (state)
            ST_IDLE:    if (arm) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = test_has_ended ? ST_DONE : test_ending ? ST_DRAIN : ST_CAPTURE;
            ST_DRAIN:   if (test_has_ended || level == '0) state_nxt = ST_DONE;
            ST_DONE:    if (!test_has_ended && arm) begin
                            state_nxt = ST_CAPTURE;
                            clr       = 1'b1;
                        end
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Saturating count of dropped or overwritten words
    always_ff @(posedge clk or posedge reset)
        if (reset)    overflow_cnt <= '0;
        else if (clr) overflow_cnt <= '0;
        else if (ovf) overflow_cnt <= sat_inc(overflow_cnt);

    sopc_cpu_oci_trace_fifo #(
        .W     (DATA_W + CNT_W),
        .DEPTH (DEPTH),
        .WRAP  (WRAP)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_data ({dct_count, dct_buffer}),
        .rd_en   (pop),
        .rd_data (rd_data),
        .level   (level),
        .ovf     (ovf)
    );

endmodule

// File: tb/tb_sopc_cpu_oci_trace_capture.sv
// tb_sopc_cpu_oci_trace_capture: directed and random checks of stop-when-full and overwrite variants against a queue model
module tb_sopc_cpu_oci_trace_capture;

    localparam int D = 4;
    typedef logic [33:0] q_t[$];

    logic        clk, reset, arm, test_ending, test_has_ended, rd_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [33:0] rd0, rd1;
    logic        rv0, rv1, dn0, dn1;
    logic [2:0]  lvl0, lvl1;
    logic [15:0] oc0, oc1;
    logic [1:0]  so0, so1;

    int vecs, errs;
    q_t q0, q1;
    int st0, st1, ov0, ov1;

    sopc_cpu_oci_trace_capture #(.DATA_W(30), .CNT_W(4), .DEPTH(D), .WRAP(0)) u0 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count), .arm(arm),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_data(rd0), .rd_valid(rv0),
        .rd_ready(rd_ready), .level(lvl0), .overflow_cnt(oc0), .state_o(so0), .done(dn0));

    sopc_cpu_oci_trace_capture #(.DATA_W(30), .CNT_W(4), .DEPTH(D), .WRAP(1)) u1 (
        .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count), .arm(arm),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .rd_data(rd1), .rd_valid(rv1),
        .rd_ready(rd_ready), .level(lvl1), .overflow_cnt(oc1), .state_o(so1), .done(dn1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] wd(input int n);
        return {4'd1, 30'(n)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic chk_model(input string nm, input q_t q, input int s, input int o,
                             input logic [2:0] lv, input logic rv, input logic [33:0] rd,
                             input logic [15:0] oc, input logic [1:0] so, input logic dn);
        bit erv;
        erv = q.size() != 0 && (s == 1 || s == 2);
        chk({nm, "_level"}, 64'(lv), 64'(q.size()));
        chk({nm, "_rd_valid"}, 64'(rv), 64'(erv));
        if (erv) chk({nm, "_rd_data"}, 64'(rd), 64'(q[0]));
        chk({nm, "_overflow"}, 64'(oc), 64'(o));
        chk({nm, "_state"}, 64'(so), 64'(s));
        chk({nm, "_done"}, 64'(dn), 64'(s == 3));
    endtask

    task automatic check_all();
        chk_model("u0", q0, st0, ov0, lvl0, rv0, rd0, oc0, so0, dn0);
        chk_model("u1", q1, st1, ov1, lvl1, rv1, rd1, oc1, so1, dn1);
    endtask

    // Behavioural model: one clock edge given the inputs currently applied
    task automatic mstep(input bit w, input q_t qi, input int si, input int oi,
                         output q_t qo, output int so, output int oo);
        q_t q;
        int s, o;
        bit rv;
        q  = qi;
        o  = oi;
        rv = q.size() != 0 && (si == 1 || si == 2);
        if (rv && rd_ready) void'(q.pop_front());
        if (si == 1 && dct_count != 0) begin
            if (q.size() < D) q.push_back({dct_count, dct_buffer});
            else begin
                if (o < 65535) o++;
                if (w) begin
                    void'(q.pop_front());
                    q.push_back({dct_count, dct_buffer});
                end
            end
        end
        case (si)
            0:       s = arm ? 1 : 0;
            1:       s = test_has_ended ? 3 : test_ending ? 2 : 1;
            2:       s = (test_has_ended || qi.size() == 0) ? 3 : 2;
            default: s = test_has_ended ? 3 : arm ? 1 : 3;
        endcase
        if (si == 3 && arm && !test_has_ended) begin
            q.delete();
            o = 0;
        end
        qo = q;
        so = s;
        oo = o;
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete();
        st0 = 0; st1 = 0; ov0 = 0; ov1 = 0;
    endtask

    task automatic step(input logic a, input logic te, input logic th, input logic [3:0] c,
                        input logic [29:0] d, input logic r);
        check_all();
        arm = a; test_ending = te; test_has_ended = th;
        dct_count = c; dct_buffer = d; rd_ready = r;
        @(posedge clk);
        mstep(1'b0, q0, st0, ov0, q0, st0, ov0);
        mstep(1'b1, q1, st1, ov1, q1, st1, ov1);
        @(negedge clk);
    endtask

    // Reset asserted away from a clock edge; outputs must clear before the next edge
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("arst_rd_data", 64'(rd0), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs = 0; errs = 0;
        reset = 1'b1; arm = 0; test_ending = 0; test_has_ended = 0;
        dct_count = 0; dct_buffer = 0; rd_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_level", 64'(lvl0), 64'd0);
        chk("rst_rd_valid", 64'(rv0), 64'd0);
        chk("rst_rd_data", 64'(rd0), 64'd0);
        chk("rst_overflow", 64'(oc0), 64'd0);
        chk("rst_state", 64'(so1), 64'd0);
        chk("rst_done", 64'(dn1), 64'd0);
        reset = 1'b0;

        // Three words streamed through with the consumer always ready
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 30'd1, 1); chk("a_rd1", 64'(rd0), 64'(wd(1)));
        step(0, 0, 0, 1, 30'd2, 1); chk("a_rd2", 64'(rd0), 64'(wd(2)));
        step(0, 0, 0, 1, 30'd3, 1); chk("a_rd3", 64'(rd0), 64'(wd(3)));
        step(0, 0, 0, 0, 0, 1);     chk("a_level0", 64'(lvl0), 64'd0);
        step(0, 0, 1, 0, 0, 0);     chk("a_done", 64'(dn0), 64'd1);

        // Six writes into four slots: drop newest vs overwrite oldest
        step(1, 0, 0, 0, 0, 0);
        for (int n = 1; n <= 6; n++) step(0, 0, 0, 1, 30'(n), 0);
        chk("b_level_stop", 64'(lvl0), 64'd4);
        chk("b_ovf_stop", 64'(oc0), 64'd2);
        chk("b_level_wrap", 64'(lvl1), 64'd4);
        chk("b_ovf_wrap", 64'(oc1), 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk("b_rd_stop", 64'(rd0), 64'(wd(1 + i)));
            chk("b_rd_wrap", 64'(rd1), 64'(wd(3 + i)));
            step(0, 0, 0, 0, 0, 1);
        end

        // Drain two entries, then DONE one cycle after the last pop
        step(0, 0, 0, 1, 30'd7, 0);
        step(0, 0, 0, 1, 30'd8, 0);
        step(0, 1, 0, 0, 0, 0); chk("c_drain", 64'(so0), 64'd2); chk("c_level2", 64'(lvl0), 64'd2);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1); chk("c_still_drain", 64'(so0), 64'd2); chk("c_empty", 64'(lvl0), 64'd0);
        step(0, 0, 0, 0, 0, 0); chk("c_done_state", 64'(so0), 64'd3); chk("c_done", 64'(dn0), 64'd1);

        // Abort a drain with three entries, then re-arm clears everything
        step(1, 0, 0, 0, 0, 0); chk("d_cleared_ovf", 64'(oc0), 64'd0);
        for (int n = 1; n <= 3; n++) step(0, 0, 0, 1, 30'(n), 0);
        step(0, 1, 0, 0, 0, 0); chk("d_drain_level", 64'(lvl0), 64'd3);
        step(0, 0, 1, 0, 0, 0); chk("d_abort_state", 64'(so0), 64'd3); chk("d_abort_rv", 64'(rv0), 64'd0);
        step(1, 0, 0, 0, 0, 0); chk("d_rearm_state", 64'(so0), 64'd1); chk("d_rearm_level", 64'(lvl0), 64'd0);
        chk("d_rearm_ovf", 64'(oc0), 64'd0);

        // Reset in the middle of a capture with three words held
        for (int n = 1; n <= 3; n++) step(0, 0, 0, 1, 30'(n), 0);
        chk("e_level3", 64'(lvl0), 64'd3);
        async_reset();
        chk("e_level_after", 64'(lvl0), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            else step($urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 79) == 0,
                      $urandom_range(0, 1) != 0 ? 4'($urandom_range(1, 15)) : 4'd0,
                      30'($urandom), $urandom_range(0, 4) < 2);
        end
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
